// File: rtl/instruction_fetch_stage.sv
// rtl/instruction_fetch_stage.sv - IF stage: fetch PC, single-outstanding imem requests, IF/ID register
// Optional misaligned-redirect tagging is enabled by defining FETCH_ALIGN_CHECK_EN.
module instruction_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic        ImemReq,
  output logic [31:0] ImemAddr,
  input  logic        ImemReady,
  input  logic        ImemRvalid,
  input  logic [31:0] ImemRdata,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD,
  output logic        FetchFaultD
);

  typedef enum logic [1:0] {
    ST_ISSUE = 2'd0,
    ST_WAIT  = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DROP  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pcf_q, pcf_d;
  logic        pcf_fault_q, pcf_fault_d;
  logic [31:0] pc_inflight_q, pc_inflight_d;
  logic        fault_inflight_q, fault_inflight_d;
  logic [31:0] hold_instr_q, hold_instr_d;
  logic [31:0] hold_pc_q, hold_pc_d;
  logic        hold_fault_q, hold_fault_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pcd_q, pcd_d;
  logic [31:0] pcplus4_q, pcplus4_d;
  logic        valid_q, valid_d;
  logic        fault_q, fault_d;

  logic        req_c;
  logic        accept;
  logic        avail;
  logic [31:0] avail_instr;
  logic [31:0] avail_pc;
  logic        avail_fault;
  logic        redirect_fault;

`ifdef FETCH_ALIGN_CHECK_EN
  assign redirect_fault = |PCTargetE[1:0];
`else
  logic unused_target_low;
  assign unused_target_low = ^PCTargetE[1:0];
  assign redirect_fault    = 1'b0;
`endif

  // Request is combinational so a response can trigger the next fetch in the same cycle.
  always_comb begin
    req_c = 1'b0;
    case (state_q)
      ST_ISSUE: req_c = 1'b1;
      ST_WAIT:  req_c = ImemRvalid & ~StallD;
      default:  req_c = 1'b0;
    endcase
    if (PCSrcE) req_c = 1'b0;
  end

  assign ImemReq  = req_c & rst;
  assign ImemAddr = {pcf_q[31:2], 2'b00};
  assign accept   = ImemReq & ImemReady;

  always_comb begin
    state_d          = state_q;
    pcf_d            = pcf_q;
    pcf_fault_d      = pcf_fault_q;
    pc_inflight_d    = pc_inflight_q;
    fault_inflight_d = fault_inflight_q;
    hold_instr_d     = hold_instr_q;
    hold_pc_d        = hold_pc_q;
    hold_fault_d     = hold_fault_q;
    instr_d          = instr_q;
    pcd_d            = pcd_q;
    pcplus4_d        = pcplus4_q;
    valid_d          = valid_q;
    fault_d          = fault_q;
    avail            = 1'b0;
    avail_instr      = ImemRdata;
    avail_pc         = pc_inflight_q;
    avail_fault      = fault_inflight_q;

    case (state_q)
      ST_ISSUE: begin
        if (!PCSrcE && accept) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (ImemRvalid) begin
          if (PCSrcE) begin
            state_d = ST_ISSUE;
          end else if (StallD) begin
            hold_instr_d = ImemRdata;
            hold_pc_d    = pc_inflight_q;
            hold_fault_d = fault_inflight_q;
            state_d      = ST_HOLD;
          end else begin
            avail   = 1'b1;
            state_d = accept ? ST_WAIT : ST_ISSUE;
          end
        end else if (PCSrcE) begin
          state_d = ST_DROP;
        end
      end
      ST_HOLD: begin
        if (PCSrcE) begin
          state_d = ST_ISSUE;
        end else if (!StallD) begin
          avail       = 1'b1;
          avail_instr = hold_instr_q;
          avail_pc    = hold_pc_q;
          avail_fault = hold_fault_q;
          state_d     = ST_ISSUE;
        end
      end
      default: begin
        if (ImemRvalid) state_d = ST_ISSUE;
      end
    endcase

    // The fault tag belongs only to the first fetch after a misaligned redirect.
    if (PCSrcE) begin
      pcf_d       = {PCTargetE[31:2], 2'b00};
      pcf_fault_d = redirect_fault;
    end else if (accept) begin
      pcf_d            = pcf_q + 32'd4;
      pcf_fault_d      = 1'b0;
      pc_inflight_d    = pcf_q;
      fault_inflight_d = pcf_fault_q;
    end

    if (FlushD) begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
      fault_d = 1'b0;
    end else if (!StallD) begin
      if (avail) begin
        instr_d   = avail_instr;
        pcd_d     = avail_pc;
        pcplus4_d = avail_pc + 32'd4;
        valid_d   = 1'b1;
        fault_d   = avail_fault;
      end else begin
        instr_d = NOP_INSTR;
        valid_d = 1'b0;
        fault_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q          <= ST_ISSUE;
      pcf_q            <= RESET_PC;
      pcf_fault_q      <= 1'b0;
      pc_inflight_q    <= RESET_PC;
      fault_inflight_q <= 1'b0;
      hold_instr_q     <= NOP_INSTR;
      hold_pc_q        <= 32'd0;
      hold_fault_q     <= 1'b0;
      instr_q          <= NOP_INSTR;
      pcd_q            <= 32'd0;
      pcplus4_q        <= 32'd0;
      valid_q          <= 1'b0;
      fault_q          <= 1'b0;
    end else begin
      state_q          <= state_d;
      pcf_q            <= pcf_d;
      pcf_fault_q      <= pcf_fault_d;
      pc_inflight_q    <= pc_inflight_d;
      fault_inflight_q <= fault_inflight_d;
      hold_instr_q     <= hold_instr_d;
      hold_pc_q        <= hold_pc_d;
      hold_fault_q     <= hold_fault_d;
      instr_q          <= instr_d;
      pcd_q            <= pcd_d;
      pcplus4_q        <= pcplus4_d;
      valid_q          <= valid_d;
      fault_q          <= fault_d;
    end
  end

  assign InstrD      = instr_q;
  assign PCD         = pcd_q;
  assign PCPlus4D    = pcplus4_q;
  assign ValidD      = valid_q;
  assign FetchFaultD = fault_q;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// tb/tb_instruction_fetch_stage.sv - randomized bench for instruction_fetch_stage against a fetch-stream model
module tb_instruction_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        StallD, FlushD, PCSrcE;
  logic [31:0] PCTargetE;
  logic        ImemReq;
  logic [31:0] ImemAddr;
  logic        ImemReady, ImemRvalid;
  logic [31:0] ImemRdata;
  logic [31:0] InstrD, PCD, PCPlus4D;
  logic        ValidD, FetchFaultD;

  always #5 clk = ~clk;

  instruction_fetch_stage dut (
    .clk(clk), .rst(rst), .StallD(StallD), .FlushD(FlushD), .PCSrcE(PCSrcE),
    .PCTargetE(PCTargetE), .ImemReq(ImemReq), .ImemAddr(ImemAddr),
    .ImemReady(ImemReady), .ImemRvalid(ImemRvalid), .ImemRdata(ImemRdata),
    .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD),
    .FetchFaultD(FetchFaultD)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0001;
  endfunction

  typedef struct {
    logic [31:0] pc;
    logic        fault;
  } fetch_t;

  // Fetches accepted by memory that decode should still see, oldest first.
  fetch_t      live[$];
  logic [31:0] exp_pc;
  logic        exp_fault_next;
  logic        mem_pend;
  logic [31:0] mem_addr;
  int          mem_cnt;
  int          delivered;

  logic        acc, p_stall, p_flush, p_pcsrc;
  logic [31:0] p_tgt, acc_addr;
  logic [31:0] pv_instr, pv_pcd, pv_pcp4;
  logic        pv_valid, pv_fault;

  initial begin
    rst = 1'b0; StallD = 1'b0; FlushD = 1'b0; PCSrcE = 1'b0; PCTargetE = 32'd0;
    ImemReady = 1'b1; ImemRvalid = 1'b0; ImemRdata = 32'd0;
    exp_pc = 32'd0; exp_fault_next = 1'b0; mem_pend = 1'b0; mem_addr = 32'd0;
    mem_cnt = 0; delivered = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req", {31'd0, ImemReq}, 32'd0);
    chk("rst_addr", ImemAddr, 32'd0);
    chk("rst_instr", InstrD, NOP);
    chk("rst_pcd", PCD, 32'd0);
    chk("rst_pcp4", PCPlus4D, 32'd0);
    chk("rst_valid", {31'd0, ValidD}, 32'd0);
    chk("rst_fault", {31'd0, FetchFaultD}, 32'd0);
    rst = 1'b1;

    for (int it = 0; it < 2500; it++) begin
      ImemRvalid = 1'b0;
      ImemRdata  = 32'd0;
      if (mem_pend) begin
        if (mem_cnt == 1) begin
          ImemRvalid = 1'b1;
          ImemRdata  = mem_word(mem_addr);
          mem_pend   = 1'b0;
        end
        mem_cnt--;
      end
      if (it < 10 || it >= 2470) begin
        StallD = 1'b0; FlushD = 1'b0; PCSrcE = 1'b0; ImemReady = 1'b1;
      end else begin
        StallD    = ($urandom % 4) == 0;
        PCSrcE    = ($urandom % 12) == 0;
        PCTargetE = ($urandom % 8 == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF))
                                        : ($urandom & 32'h0000_0FFF);
        FlushD    = PCSrcE ? (($urandom % 4) != 0) : (StallD && ($urandom % 3) == 0);
        ImemReady = ($urandom % 10) < 7;
      end
      #1;
      if (PCSrcE) chk("req_in_redirect", {31'd0, ImemReq}, 32'd0);
      acc = ImemReq & ImemReady;
      acc_addr = ImemAddr;
      if (acc) begin
        chk("fetch_addr", ImemAddr, exp_pc);
        chk("one_outstanding", {31'd0, mem_pend}, 32'd0);
      end
      p_stall = StallD; p_flush = FlushD; p_pcsrc = PCSrcE; p_tgt = PCTargetE;
      pv_instr = InstrD; pv_pcd = PCD; pv_pcp4 = PCPlus4D; pv_valid = ValidD; pv_fault = FetchFaultD;

      @(posedge clk);
      #1;
      if (acc) begin
        mem_pend = 1'b1;
        mem_addr = acc_addr;
        mem_cnt  = (it < 10) ? 1 : $urandom_range(1, 3);
      end
      if (p_pcsrc) begin
        live.delete();
        exp_pc = {p_tgt[31:2], 2'b00};
`ifdef FETCH_ALIGN_CHECK_EN
        exp_fault_next = |p_tgt[1:0];
`else
        exp_fault_next = 1'b0;
`endif
      end else if (acc) begin
        live.push_back('{pc: exp_pc, fault: exp_fault_next});
        exp_pc = exp_pc + 32'd4;
        exp_fault_next = 1'b0;
      end

      if (p_flush) begin
        chk("flush_instr", InstrD, NOP);
        chk("flush_valid", {31'd0, ValidD}, 32'd0);
        chk("flush_pcd", PCD, pv_pcd);
        chk("flush_pcp4", PCPlus4D, pv_pcp4);
      end else if (p_stall) begin
        chk("stall_instr", InstrD, pv_instr);
        chk("stall_pcd", PCD, pv_pcd);
        chk("stall_pcp4", PCPlus4D, pv_pcp4);
        chk("stall_valid", {31'd0, ValidD}, {31'd0, pv_valid});
        chk("stall_fault", {31'd0, FetchFaultD}, {31'd0, pv_fault});
      end else if (ValidD) begin
        if (live.size() == 0) begin
          chk("unexpected_instr", PCD, 32'hFFFF_FFFF);
        end else begin
          chk("ifid_pcd", PCD, live[0].pc);
          chk("ifid_instr", InstrD, mem_word(live[0].pc));
          chk("ifid_pcp4", PCPlus4D, live[0].pc + 32'd4);
          chk("ifid_fault", {31'd0, FetchFaultD}, {31'd0, live[0].fault});
          void'(live.pop_front());
          delivered++;
        end
      end else begin
        chk("bubble_instr", InstrD, NOP);
        chk("bubble_fault", {31'd0, FetchFaultD}, 32'd0);
      end

      if (it >= 1 && it < 10) chk("throughput_valid", {31'd0, ValidD}, 32'd1);
      if (it == 9) chk("first_stream_pcd", PCD, 32'd32);
    end

    chk("drain_backlog", {31'd0, live.size() <= 1}, 32'd1);
    chk("delivered_some", {31'd0, delivered > 100}, 32'd1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_stage.md
# instruction_fetch_stage

Producer side of the IF/ID interface of the pipelined RV32I core: owns the fetch PC, issues single-outstanding requests to instruction memory over a ready/valid handshake, and drives the IF/ID pipeline register (InstrD, PCD, PCPlus4D) consumed by the decode stage. It honours decode stalls, flushes and execute-stage redirects, discards stale memory responses, and inserts NOP bubbles when no instruction is available.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset
- NOP_INSTR, 32'h0000_0013, bubble encoding (addi x0,x0,0)

- clk  in  1  core clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- StallD  in  1  hold IF/ID contents
- FlushD  in  1  load bubble into IF/ID (overrides StallD)
- PCSrcE  in  1  redirect request from execute
- PCTargetE  in  32  redirect target
- ImemReq  out  1  request valid
- ImemAddr  out  32  request address (word-aligned)
- ImemReady  in  1  memory accepts request when ImemReq&ImemReady
- ImemRvalid  in  1  response valid, in order, ≥1 cycle after acceptance
- ImemRdata  in  32  response instruction word
- InstrD  out  32  IF/ID instruction
- PCD  out  32  address of InstrD
- PCPlus4D  out  32  PCD+4 (mod 2^32)
- ValidD  out  1  IF/ID holds a real instruction
- FetchFaultD  out  1  InstrD fetched from a misaligned redirect target

## Operation
- Registers: PCF (next request address), PCInFlight, HoldBuf {instr, pc, fault}, FSM, IF/ID.
- At most one outstanding request. PCF += 4 on acceptance; PCInFlight <= PCF.
- ImemAddr = {PCF[31:2], 2'b00}. ImemReq forced 0 while rst low and in any cycle with PCSrcE=1.
- FSM states:
  - ISSUE: ImemReq=1. Acceptance → WAIT.
  - WAIT: ImemReq=0 except in a cycle with ImemRvalid=1 and StallD=0 (back-to-back issue). On ImemRvalid: StallD=0 → write IF/ID; next state WAIT if a new request accepted that cycle, else ISSUE. StallD=1 → store into HoldBuf, → HOLD.
  - HOLD: ImemReq=0. When StallD=0 → HoldBuf into IF/ID, → ISSUE.
  - DROP: waiting for a stale response. ImemRvalid → discard, → ISSUE.
- Redirect (PCSrcE=1): PCF <= PCTargetE; HoldBuf invalidated. ISSUE/HOLD → ISSUE; WAIT without ImemRvalid → DROP; WAIT with ImemRvalid same cycle → response discarded, → ISSUE; DROP stays DROP.
- IF/ID update priority: FlushD → bubble (NOP_INSTR, ValidD=0, PCD/PCPlus4D unchanged); else StallD → hold; else real instruction if available (ValidD=1); else bubble.
- Response arriving in a redirect cycle is never written to IF/ID.

## Timing
- Reset values: ImemReq=0, ImemAddr=RESET_PC, InstrD=NOP_INSTR, PCD=0, PCPlus4D=0, ValidD=0, FetchFaultD=0, FSM=ISSUE, PCF=RESET_PC.
- Rst release mid-operation: in-flight response after release is not expected; reset asserted mid-request aborts everything immediately.
- Latency: request accepted cycle N, ImemRvalid cycle N+k (k≥1) → InstrD valid from cycle N+k+1.
- Throughput: 1 instruction/cycle with k=1 and ImemReady=1.
- Redirect in cycle R with idle memory: request to PCTargetE issued cycle R+1.
- PCF wraps 32'hFFFF_FFFC → 0 silently.

## Configuration
- FETCH_ALIGN_CHECK_EN defined: redirect with PCTargetE[1:0]≠0 tags the fetch; resulting IF/ID entry has FetchFaultD=1 (travels with HoldBuf), address still word-aligned on ImemAddr.
- Not defined: PCTargetE[1:0] ignored, FetchFaultD tied 0.

## Test plan
- Reset, ImemReady=1, k=1 memory → ImemAddr 0,4,8…; InstrD from 0 appears cycle 3 after release with PCD=0, PCPlus4D=4, ValidD=1, then one per cycle.
- StallD high 3 cycles while response for PC=0x10 arrives → HOLD, no ImemReq; after release InstrD=word@0x10, PCD=0x10, no instruction lost or duplicated.
- PCSrcE=1, PCTargetE=0x100 while WAIT on 0x20 (k=3) → stale 0x20 data discarded, next ImemAddr=0x100, PCD=0x100.
- FlushD=1 and StallD=1 together → InstrD=32'h13, ValidD=0.
- PCSrcE and ImemRvalid same cycle → response dropped, ValidD=0 next cycle, request to target next cycle.
- With FETCH_ALIGN_CHECK_EN, redirect to 0x102 → ImemAddr=0x100, FetchFaultD=1 with that instruction; without macro FetchFaultD=0.
